// File: rtl/step_sequencer_pkg.sv
// Shared types and constants for the step sequencer: FSM states, record
// field byte offsets, axis count and DDA accumulator width.
package step_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN
  } state_t;

  localparam int NUM_AXES = 4;
  localparam int ACC_W    = 17;

  localparam int OFF_TICKS  = 0;
  localparam int OFF_PERIOD = 2;
  localparam int OFF_STEPS  = 4;
  localparam int OFF_DIR    = 12;
  localparam int OFF_LAST   = 13;

endpackage

// File: rtl/step_pulse_stretcher.sv
// Turns a one-cycle trigger into a registered pulse that stays high for
// exactly PULSE_CLKS cycles, starting the cycle after the trigger.
module step_pulse_stretcher
  import step_sequencer_pkg::*;
#(
  parameter int PULSE_CLKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic pulse
);

  localparam int CW = (PULSE_CLKS > 1) ? $clog2(PULSE_CLKS) : 1;

  logic [CW-1:0] remaining;

  // remaining counts the high cycles still owed after the current one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse     <= 1'b0;
      remaining <= '0;
    end else if (trigger) begin
      pulse     <= 1'b1;
      remaining <= CW'(PULSE_CLKS - 1);
    end else if (remaining != '0) begin
      remaining <= remaining - 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Pops motion records from the FIFO and runs each as a timed segment, spreading
// per-axis steps evenly over the ticks with a DDA accumulator per axis.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int RECORD_WORDS = 16,
  parameter int PULSE_CLKS   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      abort,
  input  logic                      fifo_empty,
  input  logic [RECORD_WORDS*8-1:0] fifo_data,
  output logic                      fifo_read_en,
  output logic [NUM_AXES-1:0]       step,
  output logic [NUM_AXES-1:0]       dir,
  output logic                      busy,
  output logic                      segment_done,
  output logic                      underrun
);

  localparam logic [15:0] MIN_PERIOD = 16'(2 * PULSE_CLKS);

  state_t state, state_next;

  logic [15:0]         rec_ticks, rec_period;
  logic [15:0]         rec_steps [NUM_AXES];
  logic [15:0]         ticks_lat, peff_lat;
  logic [15:0]         steps_lat [NUM_AXES];
  logic [NUM_AXES-1:0] dir_lat;
  logic                last_lat;
  logic [15:0]         period_cnt, tick_cnt;
  logic [ACC_W-1:0]    acc      [NUM_AXES];
  logic [ACC_W-1:0]    acc_sum  [NUM_AXES];
  logic [ACC_W-1:0]    acc_next [NUM_AXES];
  logic [NUM_AXES-1:0] acc_over, trigger;
  logic                tick, seg_end;
  logic                unused_record;

  assign rec_ticks  = fifo_data[8*OFF_TICKS +: 16];
  assign rec_period = fifo_data[8*OFF_PERIOD +: 16];
  for (genvar k = 0; k < NUM_AXES; k++) begin : g_fields
    assign rec_steps[k] = fifo_data[8*(OFF_STEPS + 2*k) +: 16];
  end

  // Bytes past the layout and spare dir/last bits are don't-care
  assign unused_record = ^fifo_data;

  assign tick    = (state == RUN) && (period_cnt == 16'd0);
  assign seg_end = tick && (tick_cnt == 16'd1);

  always_comb begin
    state_next   = state;
    fifo_read_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (rst_n && enable && !fifo_empty && !abort) begin
          fifo_read_en = 1'b1;
          state_next   = CHECK;
        end
      end
      CHECK:   state_next = (ticks_lat == 16'd0) ? IDLE : RUN;
      RUN:     if (seg_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    for (int k = 0; k < NUM_AXES; k++) begin
      acc_sum[k]  = acc[k] + ACC_W'(steps_lat[k]);
      acc_over[k] = acc_sum[k] >= ACC_W'(ticks_lat);
      acc_next[k] = acc_over[k] ? (acc_sum[k] - ACC_W'(ticks_lat)) : acc_sum[k];
    end
  end

  assign trigger = (tick && !abort) ? acc_over : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Record latch at pop time, then per-state counter and accumulator updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticks_lat    <= '0;
      peff_lat     <= '0;
      dir_lat      <= '0;
      last_lat     <= 1'b1;
      dir          <= '0;
      period_cnt   <= '0;
      tick_cnt     <= '0;
      segment_done <= 1'b0;
      for (int k = 0; k < NUM_AXES; k++) begin
        steps_lat[k] <= '0;
        acc[k]       <= '0;
      end
    end else begin
      segment_done <= 1'b0;
      if (fifo_read_en) begin
        ticks_lat <= rec_ticks;
        peff_lat  <= (rec_period < MIN_PERIOD) ? MIN_PERIOD : rec_period;
        dir_lat   <= fifo_data[8*OFF_DIR +: NUM_AXES];
        last_lat  <= fifo_data[8*OFF_LAST];
        for (int k = 0; k < NUM_AXES; k++)
          steps_lat[k] <= (rec_steps[k] > rec_ticks) ? rec_ticks : rec_steps[k];
      end
      if (abort) begin
        period_cnt <= '0;
        tick_cnt   <= '0;
        for (int k = 0; k < NUM_AXES; k++) acc[k] <= '0;
      end else begin
        unique case (state)
          CHECK: begin
            if (ticks_lat == 16'd0) begin
              segment_done <= 1'b1;
            end else begin
              dir        <= dir_lat;
              period_cnt <= peff_lat - 16'd1;
              tick_cnt   <= ticks_lat;
              for (int k = 0; k < NUM_AXES; k++) acc[k] <= '0;
            end
          end
          RUN: begin
            if (tick) begin
              period_cnt <= peff_lat - 16'd1;
              tick_cnt   <= tick_cnt - 16'd1;
              for (int k = 0; k < NUM_AXES; k++) acc[k] <= acc_next[k];
              if (seg_end) segment_done <= 1'b1;
            end else begin
              period_cnt <= period_cnt - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        underrun <= 1'b0;
    else if (!enable)                                  underrun <= 1'b0;
    else if (state == IDLE && fifo_empty && !last_lat) underrun <= 1'b1;
  end

  for (genvar k = 0; k < NUM_AXES; k++) begin : g_pulse
    step_pulse_stretcher #(
      .PULSE_CLKS(PULSE_CLKS)
    ) u_stretcher (
      .clk    (clk),
      .rst_n  (rst_n),
      .trigger(trigger[k]),
      .pulse  (step[k])
    );
  end

  assign busy = (state != IDLE) || (step != '0);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a small FIFO model feeds records and a
// per-cycle monitor logs step edges, pops and segment_done for checking.
module tb_step_sequencer;

  localparam int RW = 16;
  localparam int PW = 4;

  logic          clk, rst_n, enable, abort, fifo_empty;
  logic [RW*8-1:0] fifo_data;
  logic          fifo_read_en, busy, segment_done, underrun;
  logic [3:0]    step, dir;

  step_sequencer #(
    .RECORD_WORDS(RW),
    .PULSE_CLKS  (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .abort       (abort),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_en(fifo_read_en),
    .step        (step),
    .dir         (dir),
    .busy        (busy),
    .segment_done(segment_done),
    .underrun    (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [RW*8-1:0] fifo_q [$];
  int         n_checks, n_errors, cyc;
  int         pulse_count [4];
  int         bad_width   [4];
  int         width       [4];
  int         rise        [4][16];
  logic [3:0] prev_step, dir_at_first;
  int         first_rise;
  int         done_count, done_cycle, pop_count;
  int         pop_cycle [8];
  logic       pend;

  function automatic logic [RW*8-1:0] make_record(input logic [15:0] n, input logic [15:0] p,
      input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
      input logic [15:0] s3, input logic [3:0] d, input logic last);
    logic [RW*8-1:0] r;
    r          = '0;
    r[15:0]    = n;
    r[31:16]   = p;
    r[47:32]   = s0;
    r[63:48]   = s1;
    r[79:64]   = s2;
    r[95:80]   = s3;
    r[99:96]   = d;
    r[103:100] = 4'hA;
    r[104]     = last;
    r[127:112] = 16'hBEEF;
    return r;
  endfunction

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push_record(input logic [RW*8-1:0] r);
    fifo_q.push_back(r);
    refresh_fifo();
  endtask

  task automatic clear_log();
    for (int k = 0; k < 4; k++) begin
      pulse_count[k] = 0;
      bad_width[k]   = 0;
      width[k]       = 0;
      for (int j = 0; j < 16; j++) rise[k][j] = -1;
    end
    prev_step    = step;
    dir_at_first = 4'hx;
    first_rise   = -1;
    done_count   = 0;
    done_cycle   = -1;
    pop_count    = 0;
    for (int j = 0; j < 8; j++) pop_cycle[j] = -1;
  endtask

  // One clock: sample at the falling edge, then apply the pop after the rising edge
  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (step[k] && !prev_step[k]) begin
        if (pulse_count[k] < 16) rise[k][pulse_count[k]] = cyc;
        pulse_count[k]++;
        width[k] = 1;
        if (first_rise < 0) begin
          first_rise   = cyc;
          dir_at_first = dir;
        end
      end else if (step[k]) begin
        width[k]++;
      end else if (prev_step[k]) begin
        if (width[k] != PW) bad_width[k]++;
      end
    end
    prev_step = step;
    if (segment_done) begin
      done_count++;
      done_cycle = cyc;
    end
    pend = fifo_read_en;
    if (fifo_read_en) begin
      if (pop_count < 8) pop_cycle[pop_count] = cyc;
      pop_count++;
    end
    @(posedge clk);
    #1;
    if (pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh_fifo();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    pend     = 1'b0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    abort    = 1'b0;
    refresh_fifo();
    #22;
    clear_log();
    check_output("reset_step", 32'(step), 0);
    check_output("reset_dir", 32'(dir), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_done", 32'(segment_done), 0);
    check_output("reset_underrun", 32'(underrun), 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    run_cycles(3);
    check_output("reset_last_no_underrun", 32'(underrun), 0);

    $display("[TB] basic segment");
    clear_log();
    push_record(make_record(16'd4, 16'd10, 16'd4, 16'd2, 16'd0, 16'd1, 4'b0101, 1'b1));
    run_cycles(60);
    check_output("basic_pops", pop_count, 1);
    check_output("basic_cnt0", pulse_count[0], 4);
    check_output("basic_cnt1", pulse_count[1], 2);
    check_output("basic_cnt2", pulse_count[2], 0);
    check_output("basic_cnt3", pulse_count[3], 1);
    check_output("basic_ax0_first", rise[0][0] - pop_cycle[0], 12);
    check_output("basic_ax0_last", rise[0][3] - pop_cycle[0], 42);
    check_output("basic_ax1_first", rise[1][0] - pop_cycle[0], 22);
    check_output("basic_ax1_second", rise[1][1] - pop_cycle[0], 42);
    check_output("basic_ax3", rise[3][0] - pop_cycle[0], 42);
    check_output("basic_widths", bad_width[0] + bad_width[1] + bad_width[3], 0);
    check_output("basic_dir", 32'(dir_at_first), 32'(4'b0101));
    check_output("basic_done_cnt", done_count, 1);
    check_output("basic_done_time", done_cycle - pop_cycle[0], 42);
    check_output("basic_idle_busy", 32'(busy), 0);
    check_output("basic_underrun", 32'(underrun), 0);

    $display("[TB] clamps");
    clear_log();
    push_record(make_record(16'd3, 16'd1, 16'd7, 16'd0, 16'd0, 16'd0, 4'b0000, 1'b1));
    run_cycles(40);
    check_output("clamp_cnt0", pulse_count[0], 3);
    check_output("clamp_first", rise[0][0] - pop_cycle[0], 10);
    check_output("clamp_gap1", rise[0][1] - rise[0][0], 8);
    check_output("clamp_gap2", rise[0][2] - rise[0][1], 8);
    check_output("clamp_width", bad_width[0], 0);
    check_output("clamp_dir", 32'(dir), 0);
    check_output("clamp_done_cnt", done_count, 1);

    $display("[TB] zero ticks");
    clear_log();
    push_record(make_record(16'd0, 16'd20, 16'd5, 16'd0, 16'd0, 16'd0, 4'b1111, 1'b1));
    run_cycles(10);
    check_output("zero_pops", pop_count, 1);
    check_output("zero_done_time", done_cycle - pop_cycle[0], 2);
    check_output("zero_no_steps", pulse_count[0] + pulse_count[1] + pulse_count[2] + pulse_count[3], 0);
    check_output("zero_dir_kept", 32'(dir), 0);

    $display("[TB] back-to-back and underrun");
    clear_log();
    push_record(make_record(16'd2, 16'd8, 16'd2, 16'd0, 16'd0, 16'd0, 4'b0011, 1'b0));
    push_record(make_record(16'd1, 16'd9, 16'd0, 16'd1, 16'd0, 16'd0, 4'b1100, 1'b0));
    run_cycles(22);
    check_output("b2b_no_early_underrun", 32'(underrun), 0);
    run_cycles(25);
    check_output("b2b_pops", pop_count, 2);
    check_output("b2b_pop_spacing", pop_cycle[1] - pop_cycle[0], 18);
    check_output("b2b_pop_after_last_tick", pop_cycle[1], rise[0][1]);
    check_output("b2b_gap", rise[1][0] - pop_cycle[1], 11);
    check_output("b2b_done_cnt", done_count, 2);
    check_output("b2b_dir", 32'(dir), 32'(4'b1100));
    check_output("b2b_underrun_set", 32'(underrun), 1);
    enable = 1'b0;
    cycle();
    check_output("b2b_underrun_clear", 32'(underrun), 0);

    $display("[TB] abort");
    clear_log();
    push_record(make_record(16'd4, 16'd10, 16'd4, 16'd0, 16'd0, 16'd0, 4'b0001, 1'b1));
    enable = 1'b1;
    for (int i = 0; i < 40 && pulse_count[0] == 0; i++) cycle();
    check_output("abort_first_pulse", pulse_count[0], 1);
    push_record(make_record(16'd4, 16'd10, 16'd4, 16'd0, 16'd0, 16'd0, 4'b0001, 1'b1));
    abort = 1'b1;
    cycle();
    cycle();
    check_output("abort_pulse_hold", 32'(step[0]), 1);
    check_output("abort_busy_pulse", 32'(busy), 1);
    cycle();
    abort  = 1'b0;
    enable = 1'b0;
    cycle();
    check_output("abort_idle", 32'(busy), 0);
    run_cycles(40);
    check_output("abort_cnt0", pulse_count[0], 1);
    check_output("abort_width", bad_width[0], 0);
    check_output("abort_no_done", done_count, 0);
    check_output("abort_no_pop", pop_count, 1);
    fifo_q.delete();
    refresh_fifo();

    $display("[TB] async reset");
    clear_log();
    push_record(make_record(16'd4, 16'd10, 16'd4, 16'd0, 16'd0, 16'd0, 4'b1010, 1'b1));
    enable = 1'b1;
    for (int i = 0; i < 40 && pulse_count[0] == 0; i++) cycle();
    check_output("rst_pre_pulse", pulse_count[0], 1);
    push_record(make_record(16'd4, 16'd10, 16'd4, 16'd0, 16'd0, 16'd0, 4'b1010, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_step", 32'(step), 0);
    check_output("rst_dir", 32'(dir), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_done", 32'(segment_done), 0);
    check_output("rst_underrun", 32'(underrun), 0);
    check_output("rst_no_read", 32'(fifo_read_en), 0);
    clear_log();
    run_cycles(2);
    check_output("rst_no_pop", pop_count, 0);
    rst_n = 1'b1;
    clear_log();
    run_cycles(60);
    check_output("resume_pops", pop_count, 1);
    check_output("resume_cnt0", pulse_count[0], 4);
    check_output("resume_first", rise[0][0] - pop_cycle[0], 12);
    check_output("resume_dir", 32'(dir_at_first), 32'(4'b1010));
    check_output("resume_done", done_count, 1);
    check_output("resume_width", bad_width[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
